// File: rtl/mul_pkg.sv
// Shared constants, FSM encoding and row-count helper for the MUL mantissa reduction tree.
package mul_pkg;

    localparam int MUL_PROD_WIDTH = 48;
    localparam int MUL_FIRST_ROWS = 13;
    localparam int MUL_MAX_ROWS   = 16;

    typedef logic [$clog2(MUL_MAX_ROWS + 1)-1:0] row_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } mul_state_e;

    // Rows left after one 3:2 pass: each full group of three becomes two, leftovers pass through.
    function automatic row_cnt_t next_row_count(input row_cnt_t r);
        return row_cnt_t'((r / row_cnt_t'(3)) * row_cnt_t'(2) + (r % row_cnt_t'(3)));
    endfunction

endpackage

// File: rtl/mul_second_stage_reducer_if.sv
// Operand-set handshake in, sum/carry pair handshake out; master drives operands, slave is the reducer.
interface mul_second_stage_reducer_if
    import mul_pkg::*;
#(
    parameter int WIDTH   = MUL_PROD_WIDTH,
    parameter int ROWS_IN = MUL_FIRST_ROWS
);
    logic                     InValid;
    logic                     InReady;
    logic [ROWS_IN*WIDTH-1:0] RowsIn;
    logic                     OutValid;
    logic                     OutReady;
    logic [WIDTH-1:0]         OutSum;
    logic [WIDTH-1:0]         OutCarry;
    logic                     Busy;

    modport master (
        output InValid, RowsIn, OutReady,
        input  InReady, OutValid, OutSum, OutCarry, Busy
    );

    modport slave (
        input  InValid, RowsIn, OutReady,
        output InReady, OutValid, OutSum, OutCarry, Busy
    );
endinterface

// File: rtl/csa_row_3to2.sv
// One row-wide 3:2 carry-save compressor built from per-column full adders.
// The carry row comes out already shifted to its column weight; the carry out of the top column is dropped.
module csa_row_3to2 #(
    parameter int WIDTH = 48
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);
    logic [WIDTH-1:0] maj;

    for (genvar i = 0; i < WIDTH; i++) begin : g_col
        FullAdder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c     (c[i]),
            .sum   (sum[i]),
            .carry (maj[i])
        );
    end

    assign carry = maj << 1;
endmodule

module FullAdder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/mul_second_stage_reducer.sv
// Iterative carry-save reducer: one 3:2 pass per clock until two rows remain (sum/carry for the final CPA).
// Latency: passes+1 edges counting the accept edge; new set accepted in the DONE cycle when the result is taken.
module mul_second_stage_reducer
    import mul_pkg::*;
#(
    parameter int WIDTH   = MUL_PROD_WIDTH,
    parameter int ROWS_IN = MUL_FIRST_ROWS
) (
    input logic                     Clk,
    input logic                     Reset,
    mul_second_stage_reducer_if.slave io
);
    localparam int NG   = ROWS_IN / 3;
    localparam int IDXW = $clog2(ROWS_IN);

    mul_state_e       state;
    row_cnt_t         rowCnt;
    row_cnt_t         nextCnt;
    logic             accept;
    logic             outValid;
    logic [WIDTH-1:0] outSum;
    logic [WIDTH-1:0] outCarry;

    logic [WIDTH-1:0] rowStore [ROWS_IN];
    logic [WIDTH-1:0] nextRows [ROWS_IN];
    logic [WIDTH-1:0] csaSum   [ROWS_IN];
    logic [WIDTH-1:0] csaCarry [ROWS_IN];

    assign io.InReady  = (state == ST_IDLE) || ((state == ST_DONE) && io.OutReady);
    assign accept      = io.InReady && io.InValid;
    assign io.Busy     = (state == ST_REDUCE);
    assign io.OutValid = outValid;
    assign io.OutSum   = outSum;
    assign io.OutCarry = outCarry;
    assign nextCnt     = next_row_count(rowCnt);

    // Compressors sit on fixed slot triples; groups beyond the live row count see zeroed slots.
    for (genvar g = 0; g < ROWS_IN; g++) begin : g_csa
        if (g < NG) begin : g_inst
            csa_row_3to2 #(.WIDTH(WIDTH)) u_csa (
                .a     (rowStore[3*g]),
                .b     (rowStore[3*g+1]),
                .c     (rowStore[3*g+2]),
                .sum   (csaSum[g]),
                .carry (csaCarry[g])
            );
        end else begin : g_none
            assign csaSum[g]   = '0;
            assign csaCarry[g] = '0;
        end
    end

    // Pack S/C pairs in group order, then the 0-2 leftover rows, then zeros.
    always_comb begin
        int grp;
        int rem;
        grp = int'(rowCnt) / 3;
        rem = int'(rowCnt) % 3;
        for (int j = 0; j < ROWS_IN; j++) begin
            nextRows[j] = '0;
            if (j < 2 * grp) begin
                nextRows[j] = (j % 2 == 1) ? csaCarry[IDXW'(j / 2)] : csaSum[IDXW'(j / 2)];
            end else if (j < 2 * grp + rem) begin
                nextRows[j] = rowStore[IDXW'(j + grp)];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            rowCnt   <= '0;
            outValid <= 1'b0;
            outSum   <= '0;
            outCarry <= '0;
            for (int k = 0; k < ROWS_IN; k++) rowStore[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < ROWS_IN; k++) rowStore[k] <= io.RowsIn[k*WIDTH +: WIDTH];
            rowCnt <= row_cnt_t'(ROWS_IN);
            if (ROWS_IN == 2) begin
                state    <= ST_DONE;
                outValid <= 1'b1;
                outSum   <= io.RowsIn[0 +: WIDTH];
                outCarry <= io.RowsIn[WIDTH +: WIDTH];
            end else begin
                state    <= ST_REDUCE;
                outValid <= 1'b0;
            end
        end else begin
            case (state)
                ST_REDUCE: begin
                    for (int k = 0; k < ROWS_IN; k++) rowStore[k] <= nextRows[k];
                    rowCnt <= nextCnt;
                    if (nextCnt == row_cnt_t'(2)) begin
                        state    <= ST_DONE;
                        outValid <= 1'b1;
                        outSum   <= nextRows[0];
                        outCarry <= nextRows[1];
                    end
                end
                ST_DONE: begin
                    if (io.OutReady) begin
                        outValid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_second_stage_reducer.sv
// Bench for the second-stage reducer: table vectors, handshake corner sequences, random streaming vs. a sum model.
module tb_mul_second_stage_reducer;
    import mul_pkg::*;

    localparam int W     = 48;
    localparam int R     = 13;
    localparam int NRAND = 1500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_second_stage_reducer_if #(.WIDTH(W), .ROWS_IN(R)) io ();
    mul_second_stage_reducer_if #(.WIDTH(W), .ROWS_IN(2)) io2 ();

    mul_second_stage_reducer #(.WIDTH(W), .ROWS_IN(R)) dut  (.Clk(clk), .Reset(rst), .io(io));
    mul_second_stage_reducer #(.WIDTH(W), .ROWS_IN(2)) dut2 (.Clk(clk), .Reset(rst), .io(io2));

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        string        name;
        logic [W-1:0] base;
        logic [W-1:0] step;
        logic [W-1:0] expSum;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [R*W-1:0] mkRows(input logic [W-1:0] base, input logic [W-1:0] step);
        logic [R*W-1:0] r;
        for (int k = 0; k < R; k++) r[k*W +: W] = base + W'(k) * step;
        return r;
    endfunction

    function automatic logic [W-1:0] outTotal();
        logic [W-1:0] s;
        s = io.OutSum + io.OutCarry;
        return s;
    endfunction

    task automatic genRows(output logic [R*W-1:0] r, output logic [W-1:0] s);
        logic [63:0] t;
        r = '0;
        s = '0;
        for (int k = 0; k < R; k++) begin
            t = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) t = '1;
            r[k*W +: W] = t[W-1:0];
            s = s + t[W-1:0];
        end
    endtask

    // Counts edges from the accept edge (edge 1) until OutValid is seen.
    task automatic waitOut(output int edges);
        edges = 1;
        while (!io.OutValid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic sendAndCheck(input logic [R*W-1:0] rows, input logic [W-1:0] expSum, input string tag);
        int edges;
        io.RowsIn   = rows;
        io.InValid  = 1'b1;
        io.OutReady = 1'b0;
        @(posedge clk); #1;
        io.InValid = 1'b0;
        io.RowsIn  = ~rows;
        check($sformatf("%s_busy", tag), 64'(io.Busy), 64'd1);
        waitOut(edges);
        check($sformatf("%s_latency", tag), 64'(edges), 64'd6);
        check($sformatf("%s_sum", tag), 64'(outTotal()), 64'(expSum));
    endtask

    task automatic drain(input string tag);
        io.OutReady = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s_drain_valid", tag), 64'(io.OutValid), 64'd0);
        io.OutReady = 1'b0;
    endtask

    initial begin
        int edges;
        logic [R*W-1:0] cur;
        logic [W-1:0]   curSum;
        logic [W-1:0]   expQ[$];
        logic [W-1:0]   exp;
        logic [W-1:0]   a2;
        logic [W-1:0]   b2;
        int txSent;
        int txDone;
        bit acc;

        vecs[0] = '{"ones",     48'h1,              48'h0,    48'd13};
        vecs[1] = '{"allones",  48'hFFFF_FFFF_FFFF, 48'h0,    48'hFFFF_FFFF_FFF3};
        vecs[2] = '{"ramp",     48'h1,              48'h1,    48'd91};
        vecs[3] = '{"zero",     48'h0,              48'h0,    48'd0};
        vecs[4] = '{"msb",      48'h8000_0000_0000, 48'h0,    48'h8000_0000_0000};
        vecs[5] = '{"stride",   48'd100,            48'd1000, 48'd79300};

        io.InValid   = 1'b0;
        io.RowsIn    = '0;
        io.OutReady  = 1'b0;
        io2.InValid  = 1'b0;
        io2.RowsIn   = '0;
        io2.OutReady = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outvalid", 64'(io.OutValid), 64'd0);
        check("reset_inready",  64'(io.InReady),  64'd1);
        check("reset_busy",     64'(io.Busy),     64'd0);
        check("reset_outsum",   64'(io.OutSum),   64'd0);
        check("reset_outcarry", 64'(io.OutCarry), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            sendAndCheck(mkRows(vecs[i].base, vecs[i].step), vecs[i].expSum, vecs[i].name);
            drain(vecs[i].name);
        end

        // Backpressure: result held for 10 cycles, no new set accepted.
        sendAndCheck(mkRows(48'd2, 48'd5), 48'd416, "bp");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_hold_valid",   64'(io.OutValid),  64'd1);
            check("bp_hold_inready", 64'(io.InReady),   64'd0);
            check("bp_hold_sum",     64'(outTotal()),   64'd416);
        end
        io.OutReady = 1'b1;
        #1;
        check("bp_release_inready", 64'(io.InReady), 64'd1);
        @(posedge clk); #1;
        check("bp_release_valid", 64'(io.OutValid), 64'd0);
        check("bp_release_busy",  64'(io.Busy),     64'd0);
        io.OutReady = 1'b0;

        // Back-to-back: second set accepted on the same edge the first result is taken.
        sendAndCheck(mkRows(48'h1, 48'h0), 48'd13, "b2b_first");
        io.OutReady = 1'b1;
        io.InValid  = 1'b1;
        io.RowsIn   = mkRows(48'd7, 48'd3);
        #1;
        check("b2b_inready", 64'(io.InReady), 64'd1);
        @(posedge clk); #1;
        io.InValid  = 1'b0;
        io.OutReady = 1'b0;
        io.RowsIn   = '1;
        check("b2b_valid_drop", 64'(io.OutValid), 64'd0);
        check("b2b_busy",       64'(io.Busy),     64'd1);
        waitOut(edges);
        check("b2b_latency", 64'(edges), 64'd6);
        check("b2b_sum", 64'(outTotal()), 64'd325);
        drain("b2b");

        // Reset during the third pass discards the set.
        io.RowsIn  = mkRows(48'hFFFF_FFFF_FFFF, 48'h0);
        io.InValid = 1'b1;
        @(posedge clk); #1;
        io.InValid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_outvalid", 64'(io.OutValid), 64'd0);
        check("midrst_inready",  64'(io.InReady),  64'd1);
        check("midrst_busy",     64'(io.Busy),     64'd0);
        sendAndCheck(mkRows(48'h1, 48'h1), 48'd91, "midrst_fresh");
        drain("midrst_fresh");

        // Two-row build: result appears right after the accept edge.
        io2.RowsIn  = {48'hA, 48'h5};
        io2.InValid = 1'b1;
        @(posedge clk); #1;
        io2.InValid = 1'b0;
        check("two_outvalid", 64'(io2.OutValid), 64'd1);
        check("two_outsum",   64'(io2.OutSum),   64'd5);
        check("two_outcarry", 64'(io2.OutCarry), 64'd10);
        check("two_busy",     64'(io2.Busy),     64'd0);
        io2.OutReady = 1'b1;
        @(posedge clk); #1;
        io2.OutReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a2 = W'({$urandom(), $urandom()});
            b2 = W'({$urandom(), $urandom()});
            io2.RowsIn  = {b2, a2};
            io2.InValid = 1'b1;
            @(posedge clk); #1;
            io2.InValid = 1'b0;
            check("two_rand_sum",   64'(io2.OutSum),   64'(a2));
            check("two_rand_carry", 64'(io2.OutCarry), 64'(b2));
            io2.OutReady = 1'b1;
            @(posedge clk); #1;
            io2.OutReady = 1'b0;
        end

        // Random streaming with random backpressure against a queue of reference sums.
        txSent = 0;
        txDone = 0;
        cur    = '0;
        curSum = '0;
        for (int cyc = 0; cyc < 30000 && txDone < NRAND; cyc++) begin
            if (!io.InValid && txSent < NRAND && $urandom_range(0, 3) != 0) begin
                genRows(cur, curSum);
                io.RowsIn  = cur;
                io.InValid = 1'b1;
            end
            io.OutReady = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (io.OutValid && io.OutReady) begin
                if (expQ.size() == 0) begin
                    check("rand_unexpected_output", 64'd1, 64'd0);
                end else begin
                    exp = expQ.pop_front();
                    check("rand_sum", 64'(outTotal()), 64'(exp));
                end
                txDone++;
            end
            acc = io.InValid && io.InReady;
            if (acc) begin
                expQ.push_back(curSum);
                txSent++;
            end
            @(posedge clk); #1;
            if (acc) begin
                io.InValid = 1'b0;
                io.RowsIn  = {R{48'hDEAD_BEEF_CAFE}};
            end
        end
        io.InValid  = 1'b0;
        io.OutReady = 1'b0;
        check("rand_completed", 64'(txDone), 64'(NRAND));
        check("rand_queue_empty", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
